// File: rtl/pixel_writer_pkg.sv
// Shared types for the pixel writer: FSM encoding, FIFO entry record
// and the framebuffer address helper.
package pixel_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    localparam int ENTRY_W = 24;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] color;
    } pix_t;

    // Row-major byte address; 16 bits is enough for any legal FB size.
    function automatic logic [15:0] pix_addr(
        input logic [7:0] x,
        input logic [7:0] y,
        input int unsigned w
    );
        return 16'(y) * 16'(w) + 16'(x);
    endfunction

endpackage

// File: rtl/pixel_writer_if.sv
// Pixel stream from the line/shape drawer to the pixel writer.
// master: drawer (valid, x, y, color out; ready in). slave: writer.
interface pixel_writer_if;

    logic       pix_valid;
    logic       pix_ready;
    logic [7:0] pix_x;
    logic [7:0] pix_y;
    logic [7:0] pix_color;

    modport master (
        output pix_valid, pix_x, pix_y, pix_color,
        input  pix_ready
    );

    modport slave (
        input  pix_valid, pix_x, pix_y, pix_color,
        output pix_ready
    );

endinterface

// File: rtl/pixel_fifo.sv
// Synchronous FIFO: push/pop, full/empty flags and occupancy count.
// Ports: ACLK, reset, push/wdata, pop/rdata (head, show-ahead), full, empty, count.
module pixel_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic                     ACLK,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    assign rdata = store[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge ACLK) begin
        if (push) begin
            store[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge ACLK) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pixel_writer.sv
// Buffers drawer pixels, clips off-screen ones and writes the rest to the framebuffer.
// Ports: ACLK, reset, pix (slave stream), flush/flush_done, mem_req/addr/wdata/ack, clip_count, busy.
module pixel_writer
    import pixel_writer_pkg::*;
#(
    parameter int FB_W       = 160,
    parameter int FB_H       = 120,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          ACLK,
    input  logic          reset,
    pixel_writer_if.slave pix,
    input  logic          flush,
    output logic          flush_done,
    output logic          mem_req,
    output logic [15:0]   mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic          mem_ack,
    output logic [15:0]   clip_count,
    output logic          busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t          state;
    state_t          state_nxt;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   occ;
    logic            accept;
    logic            in_range;
    logic            push;
    logic            pop;
    logic            pending;
    pix_t            in_ent;
    pix_t            head;
    pix_t            cur;

    assign pix.pix_ready = !fifo_full;
    assign accept        = pix.pix_valid && !fifo_full;
    assign in_range      = ({1'b0, pix.pix_x} < 9'(FB_W)) &&
                           ({1'b0, pix.pix_y} < 9'(FB_H));
    assign push          = accept && in_range;
    assign in_ent        = '{x: pix.pix_x, y: pix.pix_y, color: pix.pix_color};

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .ACLK  (ACLK),
        .reset (reset),
        .push  (push),
        .wdata (in_ent),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (occ)
    );

    always_ff @(posedge ACLK) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) state_nxt = ST_ADDR;
            end
            ST_ADDR: begin
                state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                if (mem_ack) state_nxt = fifo_empty ? ST_IDLE : ST_ADDR;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Pop whenever the FSM is about to enter ADDR.
    always_comb begin
        mem_req = 1'b0;
        pop     = 1'b0;
        unique case (state)
            ST_IDLE:  pop = !fifo_empty;
            ST_ADDR:  pop = 1'b0;
            ST_WRITE: begin
                mem_req = 1'b1;
                pop     = mem_ack && !fifo_empty;
            end
            default: begin
                mem_req = 1'b0;
                pop     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (reset) begin
            cur       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if (pop) begin
                cur <= head;
            end
            if (state == ST_ADDR) begin
                mem_addr  <= pix_addr(cur.x, cur.y, FB_W);
                mem_wdata <= cur.color;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (reset) begin
            clip_count <= '0;
        end else if (accept && !in_range && clip_count != 16'hFFFF) begin
            clip_count <= clip_count + 16'd1;
        end
    end

    // A flush arriving while one is pending (including the done cycle) merges into it.
    assign flush_done = pending && fifo_empty && (state == ST_IDLE);

    always_ff @(posedge ACLK) begin
        if (reset) begin
            pending <= 1'b0;
        end else if (flush_done) begin
            pending <= 1'b0;
        end else if (flush) begin
            pending <= 1'b1;
        end
    end

    assign busy = (occ != '0) || (state != ST_IDLE);

endmodule
